lcd_init_seq: RTL and testbench
===============================

// Module: lcd_init_seq
// PURPOSE
//  Upstream byte source for the LCD serializer. On start, pulses the panel hardware reset,
//  walks an init-command ROM (command bytes, parameter bytes, timed delays), then passes
//  pixel bytes from a pixel stream through. Drives dc/cs_n in lock-step with tx handshakes,
//  so dc never changes while a byte is still shifting out.
// PARAMETERS
//  WORD_WIDTH  8       byte width on tx/px ports; must match the serializer
//  ROM_DEPTH   64      init ROM entries; address width $clog2(ROM_DEPTH)
//  DELAY_UNIT  27000   clk cycles per delay unit (1 ms @ 27 MHz)
//  RST_CYCLES  270000  cycles lcd_rst_n held low, then again high before the first command
// PORTS
//  clk        in   1           clock
//  rst        in   1           reset, asynchronous, active-low
//  start      in   1           1-cycle pulse; begins sequence; honoured only in IDLE
//  busy       out  1           high in every state except IDLE
//  init_done  out  1           high in STREAM
//  lcd_rst_n  out  1           panel hardware reset, active-low
//  cs_n       out  1           panel chip select, active-low
//  dc         out  1           0 = command byte, 1 = data/parameter/pixel byte
//  tx_valid   out  1           byte offer to serializer
//  tx_ready   in   1           serializer idle/accepting
//  tx_data    out  WORD_WIDTH  byte to serializer
//  px_valid   in   1           pixel byte offer
//  px_ready   out  1           pixel byte accepted
//  px_data    in   WORD_WIDTH  pixel byte
// BEHAVIOUR
//  Reset values: busy=0 init_done=0 lcd_rst_n=1 cs_n=1 dc=0 tx_valid=0 tx_data=0 px_ready=0;
//   state=IDLE, rom_addr=0, counters=0. Reset mid-operation aborts immediately, no drain.
//  ROM entry = {type[1:0], payload[7:0]}: CMD=00, DATA=01, DELAY=10 (payload units), END=11.
//   Entry at ROM_DEPTH-1 is treated as END whatever it holds.
//  Handshake: transfer on tx_valid&&tx_ready. tx_valid/tx_data are stable until accepted.
//  dc is registered and updated only on the cycle of a transfer (takes the accepted byte's
//   type). It changes on the same edge the serializer latches the byte.
//  States:
//   IDLE     -> HWRST_LO on start.
//   HWRST_LO lcd_rst_n=0 for RST_CYCLES cycles -> HWRST_HI.
//   HWRST_HI lcd_rst_n=1 for RST_CYCLES cycles -> FETCH. cs_n=0 from FETCH onward.
//   FETCH    registers rom[rom_addr] (1 cycle).
//            CMD/DATA -> SEND; DELAY -> DRAIN; END -> DRAIN (stream flagged).
//   SEND     tx_valid=1, tx_data=payload. On transfer: rom_addr++, dc=type[0] -> FETCH.
//   DRAIN    waits for the serializer to finish the last byte. Exits when tx_ready=1 and no
//            transfer happened in the previous cycle. DELAY -> WAIT; END -> STREAM.
//   WAIT     counts payload*DELAY_UNIT cycles using a DELAY_UNIT prescaler and an 8-bit
//            unit counter; payload 0 exits after 1 cycle. Then rom_addr++ -> FETCH.
//   STREAM   init_done=1. Combinational pass-through: tx_valid=px_valid, tx_data=px_data,
//            px_ready=tx_ready. dc set to 1 on the first transfer. Stays here until reset.
//  px_ready=0 and px_valid is ignored outside STREAM. tx_valid=0 outside SEND/STREAM.
//  Back-to-back CMD/DATA: one byte per serializer cycle (9 clk with an 8-bit word). Adds no
//   bubble beyond the 1 FETCH cycle, which overlaps serializer shifting.
//  start while busy: ignored. rom_addr never wraps, because the last entry is forced END.
// STRUCTURE
//  lcd_pkg: entry_type_t enum (CMD, DATA, DELAY, END), ENTRY_W=10, seq_state_t enum
//   (IDLE, HWRST_LO, HWRST_HI, FETCH, SEND, DRAIN, WAIT, STREAM).
//  Sub-module lcd_init_rom: combinational case table, rom_addr -> ENTRY_W entry,
//   param ROM_DEPTH, panel-specific contents only.
//  Single registered FSM + counters + combinational output mux.
// TESTING  (bench params: DELAY_UNIT=4, RST_CYCLES=8; serializer model ready low 8 cyc/byte)
//  1 Reset/start: rst low mid-HWRST_LO -> all outputs at reset values next cycle.
//    start -> lcd_rst_n low exactly 8 cyc, high 8 cyc, then cs_n=0.
//  2 ROM {CMD 0x11, DELAY 2, CMD 0x29, END} -> tx bytes 0x11 then 0x29, both dc=0.
//    Gap from 0x11 serializer-done to 0x29 offer >= 8 cyc. Then init_done=1.
//  3 ROM {CMD 0x3A, DATA 0x55, END} -> dc=0 during 0x3A shift, 1 during 0x55 shift.
//    dc toggles only on the 0x55 transfer edge.
//  4 STREAM: px bytes 0xF8,0x00 with tx_ready stalls -> tx_data matches, dc=1.
//    px_ready mirrors tx_ready. No byte lost or duplicated.
//  5 DELAY 0 and ROM with no END (all CMD) -> delay exits in 1 cycle.
//    Sequencer sends ROM_DEPTH-1 bytes, then enters STREAM.
//  6 start pulsed during SEND and STREAM -> ignored. px_valid outside STREAM -> px_ready=0.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and helpers for the LCD init sequencer.
//  entry_type_t : init-ROM entry kinds (CMD, DATA, DELAY, END)
//  seq_state_t  : sequencer FSM states
//  ENTRY_W      : ROM entry width, {type[1:0], payload[7:0]}
package lcd_pkg;

  localparam int ENTRY_W = 10;

  typedef enum logic [1:0] {
    CMD   = 2'b00,
    DATA  = 2'b01,
    DELAY = 2'b10,
    END   = 2'b11
  } entry_type_t;

  typedef enum logic [2:0] {
    IDLE,
    HWRST_LO,
    HWRST_HI,
    FETCH,
    SEND,
    DRAIN,
    WAIT,
    STREAM
  } seq_state_t;

  function automatic logic [ENTRY_W-1:0] make_entry(input entry_type_t kind,
                                                    input logic [7:0] payload);
    return {kind, payload};
  endfunction

  function automatic entry_type_t entry_kind(input logic [ENTRY_W-1:0] entry);
    return entry_type_t'(entry[9:8]);
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: combinational init-command table for the panel.
//  addr  in   $clog2(ROM_DEPTH)  entry address
//  entry out  ENTRY_W            {type[1:0], payload[7:0]}
// INIT_IMAGE selects the table:
//  0 = panel bring-up: sleep-out, 2-unit delay, 16-bit colour mode, display-on.
//  1 = flat command walk (payload 0xC0|addr in every slot, no END) used to
//      exercise the serializer link; the sequencer forces the last slot to END.
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int ROM_DEPTH  = 64,
  parameter int INIT_IMAGE = 0,
  parameter int AW         = $clog2(ROM_DEPTH)
) (
  input  logic [AW-1:0]      addr,
  output logic [ENTRY_W-1:0] entry
);

  always_comb begin
    entry = make_entry(END, 8'h00);
    if (INIT_IMAGE == 0) begin
      case (addr)
        AW'(0):  entry = make_entry(CMD,   8'h11);  // sleep out
        AW'(1):  entry = make_entry(DELAY, 8'h02);  // wake-up settle
        AW'(2):  entry = make_entry(CMD,   8'h3A);  // pixel format
        AW'(3):  entry = make_entry(DATA,  8'h55);  // 16 bpp
        AW'(4):  entry = make_entry(DELAY, 8'h00);
        AW'(5):  entry = make_entry(CMD,   8'h29);  // display on
        default: entry = make_entry(END,   8'h00);
      endcase
    end else begin
      entry = make_entry(CMD, 8'hC0 | 8'(addr));
    end
  end

endmodule

// File: rtl/lcd_init_seq.sv
// lcd_init_seq: byte source feeding the LCD serializer.
// Pulses the panel hardware reset, walks the init ROM (commands, parameters,
// timed delays), then passes pixel bytes straight through.
//  clk        in   clock
//  rst        in   asynchronous active-low reset
//  start      in   1-cycle start pulse, honoured only in IDLE
//  busy       out  high in every state except IDLE
//  init_done  out  high in STREAM
//  lcd_rst_n  out  panel hardware reset (active-low)
//  cs_n       out  panel chip select (active-low), low from FETCH onward
//  dc         out  0 = command, 1 = data/parameter/pixel; updated on transfers
//  tx_valid   out  byte offer to serializer
//  tx_ready   in   serializer idle/accepting
//  tx_data    out  byte to serializer
//  px_valid   in   pixel byte offer
//  px_ready   out  pixel byte accepted (STREAM only)
//  px_data    in   pixel byte
module lcd_init_seq
  import lcd_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int ROM_DEPTH  = 64,
  parameter int DELAY_UNIT = 27000,
  parameter int RST_CYCLES = 270000,
  parameter int INIT_IMAGE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  init_done,
  output logic                  lcd_rst_n,
  output logic                  cs_n,
  output logic                  dc,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [WORD_WIDTH-1:0] tx_data,
  input  logic                  px_valid,
  output logic                  px_ready,
  input  logic [WORD_WIDTH-1:0] px_data
);

  localparam int          AW         = $clog2(ROM_DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(ROM_DEPTH - 1);
  localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
  localparam logic [31:0] UNIT_LAST  = 32'(DELAY_UNIT - 1);

  seq_state_t         state_reg, state_next;
  logic [AW-1:0]      rom_addr_reg, rom_addr_next;
  logic [31:0]        cnt_reg, cnt_next;
  logic [7:0]         unit_reg, unit_next;
  logic [ENTRY_W-1:0] entry_reg, entry_next;
  logic               dc_reg, dc_next;
  logic               xfer_d_reg;
  logic [ENTRY_W-1:0] rom_entry;
  logic               xfer;

  lcd_init_rom #(
    .ROM_DEPTH  (ROM_DEPTH),
    .INIT_IMAGE (INIT_IMAGE),
    .AW         (AW)
  ) u_rom (
    .addr  (rom_addr_reg),
    .entry (rom_entry)
  );

  assign xfer = tx_valid && tx_ready;
  assign dc   = dc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      rom_addr_reg <= '0;
      cnt_reg      <= '0;
      unit_reg     <= '0;
      entry_reg    <= '0;
      dc_reg       <= 1'b0;
      xfer_d_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rom_addr_reg <= rom_addr_next;
      cnt_reg      <= cnt_next;
      unit_reg     <= unit_next;
      entry_reg    <= entry_next;
      dc_reg       <= dc_next;
      xfer_d_reg   <= xfer;
    end
  end

  always_comb begin
    state_next    = state_reg;
    rom_addr_next = rom_addr_reg;
    cnt_next      = cnt_reg;
    unit_next     = unit_reg;
    entry_next    = entry_reg;
    dc_next       = dc_reg;
    busy          = (state_reg != IDLE);
    init_done     = 1'b0;
    lcd_rst_n     = 1'b1;
    cs_n          = 1'b1;
    tx_valid      = 1'b0;
    tx_data       = '0;
    px_ready      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = HWRST_LO;
          cnt_next   = '0;
        end
      end

      HWRST_LO: begin
        lcd_rst_n = 1'b0;
        if (cnt_reg == RST_LAST) begin
          cnt_next   = '0;
          state_next = HWRST_HI;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      HWRST_HI: begin
        if (cnt_reg == RST_LAST) begin
          cnt_next   = '0;
          state_next = FETCH;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      FETCH: begin
        cs_n = 1'b0;
        // The last slot is an END no matter what the table holds, so
        // rom_addr can never run off the end of the ROM.
        entry_next = (rom_addr_reg == LAST_ADDR) ? make_entry(END, 8'h00) : rom_entry;
        case (entry_kind(entry_next))
          CMD, DATA: state_next = SEND;
          default:   state_next = DRAIN;
        endcase
      end

      SEND: begin
        cs_n     = 1'b0;
        tx_valid = 1'b1;
        tx_data  = WORD_WIDTH'(entry_reg[7:0]);
        if (tx_ready) begin
          rom_addr_next = rom_addr_reg + AW'(1);
          dc_next       = entry_reg[8];
          state_next    = FETCH;
        end
      end

      DRAIN: begin
        cs_n = 1'b0;
        // A serializer may still show ready in the cycle right after it
        // latched a byte; ignore that cycle so the last byte fully shifts out.
        if (tx_ready && !xfer_d_reg) begin
          if (entry_kind(entry_reg) == DELAY) begin
            state_next = WAIT;
            cnt_next   = '0;
            unit_next  = '0;
          end else begin
            state_next = STREAM;
          end
        end
      end

      WAIT: begin
        cs_n = 1'b0;
        if (entry_reg[7:0] == 8'd0) begin
          rom_addr_next = rom_addr_reg + AW'(1);
          state_next    = FETCH;
        end else if (cnt_reg == UNIT_LAST) begin
          cnt_next = '0;
          if (unit_reg == entry_reg[7:0] - 8'd1) begin
            rom_addr_next = rom_addr_reg + AW'(1);
            state_next    = FETCH;
          end else begin
            unit_next = unit_reg + 8'd1;
          end
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end

      STREAM: begin
        cs_n      = 1'b0;
        init_done = 1'b1;
        tx_valid  = px_valid;
        tx_data   = px_data;
        px_ready  = tx_ready;
        if (px_valid && tx_ready) begin
          dc_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lcd_init_seq.sv
`timescale 1ns/1ps
module tb_lcd_init_seq;
  import lcd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start_a, busy_a, init_done_a, lcd_rst_n_a, cs_n_a, dc_a;
  logic       tx_valid_a, tx_ready_a, px_valid_a, px_ready_a;
  logic [7:0] tx_data_a, px_data_a;
  logic       start_b, busy_b, init_done_b, lcd_rst_n_b, cs_n_b, dc_b;
  logic       tx_valid_b, tx_ready_b, px_valid_b, px_ready_b;
  logic [7:0] tx_data_b, px_data_b;

  // A: panel table; B: flat command walk with no END in the table.
  lcd_init_seq #(.WORD_WIDTH(8), .ROM_DEPTH(16), .DELAY_UNIT(4), .RST_CYCLES(8), .INIT_IMAGE(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .init_done(init_done_a),
    .lcd_rst_n(lcd_rst_n_a), .cs_n(cs_n_a), .dc(dc_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .tx_data(tx_data_a), .px_valid(px_valid_a),
    .px_ready(px_ready_a), .px_data(px_data_a)
  );

  lcd_init_seq #(.WORD_WIDTH(8), .ROM_DEPTH(8), .DELAY_UNIT(4), .RST_CYCLES(8), .INIT_IMAGE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .init_done(init_done_b),
    .lcd_rst_n(lcd_rst_n_b), .cs_n(cs_n_b), .dc(dc_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx_data(tx_data_b), .px_valid(px_valid_b),
    .px_ready(px_ready_b), .px_data(px_data_b)
  );

  wire [14:0] outs_a = {busy_a, init_done_a, lcd_rst_n_a, cs_n_a, dc_a, tx_valid_a, tx_data_a, px_ready_a};
  localparam logic [14:0] RST_OUTS = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serializer model: after accepting a byte it is busy (ready low) for 8 cycles.
  logic [3:0] ser_cnt_a, ser_cnt_b;
  logic       stall_a;

  always @(posedge clk or negedge rst) begin
    if (!rst) ser_cnt_a <= 4'd0;
    else if (tx_valid_a && tx_ready_a) ser_cnt_a <= 4'd8;
    else if (ser_cnt_a != 4'd0) ser_cnt_a <= ser_cnt_a - 4'd1;
  end
  assign tx_ready_a = (ser_cnt_a == 4'd0) && !stall_a;

  always @(posedge clk or negedge rst) begin
    if (!rst) ser_cnt_b <= 4'd0;
    else if (tx_valid_b && tx_ready_b) ser_cnt_b <= 4'd8;
    else if (ser_cnt_b != 4'd0) ser_cnt_b <= ser_cnt_b - 4'd1;
  end
  assign tx_ready_b = (ser_cnt_b == 4'd0);

  // Scoreboard entries: byte, dc it must carry, ready-idle cycles before it (-1 = any).
  typedef struct {
    logic [7:0] data;
    logic       dc;
    int         gap;
  } exp_t;

  typedef struct {
    logic [7:0] px;
    int         stall;
    logic [7:0] exp_data;
    logic       exp_dc;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Monitor A, sampled mid-cycle: a handshake seen here completes at the next edge.
  exp_t       e_a;
  logic       xfer_last_a = 1'b0;
  logic       dc_exp_a    = 1'b0;
  logic       dc_prev_a   = 1'b0;
  logic [3:0] cnt_last_a  = 4'd0;
  int         idle_a      = 0;
  int         xcnt_a      = 0;

  always @(negedge clk) begin
    if (!rst) begin
      xfer_last_a = 1'b0;
      cnt_last_a  = 4'd0;
      idle_a      = 0;
    end else begin
      if (xfer_last_a) check("dc_after_xfer_a", int'(dc_a), int'(dc_exp_a));
      else if (cnt_last_a != 4'd0) check("dc_stable_while_shifting_a", int'(dc_a), int'(dc_prev_a));
      xfer_last_a = 1'b0;
      if (tx_valid_a && tx_ready_a) begin
        xcnt_a++;
        if (q_a.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_byte_a: got 0x%0h, want no transfer", tx_data_a);
        end else begin
          e_a = q_a.pop_front();
          $display("xfer A: data=0x%02h expect=0x%02h dc_expect=%0d idle=%0d", tx_data_a, e_a.data, e_a.dc, idle_a);
          check("tx_data_a", int'(tx_data_a), int'(e_a.data));
          if (e_a.gap >= 0) check("ready_idle_gap_a", idle_a, e_a.gap);
          dc_exp_a    = e_a.dc;
          xfer_last_a = 1'b1;
        end
        idle_a = 0;
      end else if (tx_valid_a) begin
        idle_a = 0;
      end else if (tx_ready_a) begin
        idle_a++;
      end
      dc_prev_a  = dc_a;
      cnt_last_a = ser_cnt_a;
    end
  end

  // Monitor B.
  exp_t e_b;
  logic xfer_last_b = 1'b0;
  logic dc_exp_b    = 1'b0;
  int   xcnt_b      = 0;

  always @(negedge clk) begin
    if (!rst) begin
      xfer_last_b = 1'b0;
    end else begin
      if (xfer_last_b) check("dc_after_xfer_b", int'(dc_b), int'(dc_exp_b));
      xfer_last_b = 1'b0;
      if (tx_valid_b && tx_ready_b) begin
        xcnt_b++;
        if (q_b.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_byte_b: got 0x%0h, want no transfer", tx_data_b);
        end else begin
          e_b = q_b.pop_front();
          $display("xfer B: data=0x%02h expect=0x%02h", tx_data_b, e_b.data);
          check("tx_data_b", int'(tx_data_b), int'(e_b.data));
          dc_exp_b    = e_b.dc;
          xfer_last_b = 1'b1;
        end
      end
    end
  end

  initial begin
    exp_t rom_tab[4];
    vec_t px_tab[4];
    int   n, lo, hi, xc;

    rom_tab[0] = '{8'h11, 1'b0, -1};
    rom_tab[1] = '{8'h3A, 1'b0, 10};  // DRAIN 1 + DELAY 2*4 + FETCH 1
    rom_tab[2] = '{8'h55, 1'b1, 0};   // back-to-back, offered while still shifting
    rom_tab[3] = '{8'h29, 1'b0, 3};   // DRAIN 1 + DELAY 0 (1 cycle) + FETCH 1
    px_tab[0]  = '{8'hF8, 3, 8'hF8, 1'b1};
    px_tab[1]  = '{8'h00, 0, 8'h00, 1'b1};
    px_tab[2]  = '{8'hA5, 12, 8'hA5, 1'b1};
    px_tab[3]  = '{8'h3C, 1, 8'h3C, 1'b1};

    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; stall_a = 1'b0;
    px_valid_a = 1'b0; px_data_a = 8'h00; px_valid_b = 1'b0; px_data_b = 8'h00;

    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs_a", int'(outs_a), int'(RST_OUTS));
    tick();
    rst = 1'b1;
    tick();

    // Abort in the middle of the hardware-reset pulse.
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (3) tick();
    check("hwrst_lo_active", int'(lcd_rst_n_a), 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs_a", int'(outs_a), int'(RST_OUTS));
    tick();
    rst = 1'b1;
    tick();

    // Full init sequence.
    foreach (rom_tab[i]) q_a.push_back(rom_tab[i]);
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0; lo = 0; hi = 0;
    @(negedge clk);
    while (!lcd_rst_n_a && n < 40) begin lo++; n++; @(negedge clk); end
    while (lcd_rst_n_a && cs_n_a && n < 80) begin hi++; n++; @(negedge clk); end
    check("lcd_rst_n_low_cycles", lo, 8);
    check("lcd_rst_n_high_cycles", hi, 8);
    check("cs_n_after_hwrst", int'(cs_n_a), 0);
    $display("hwrst: low=%0d high=%0d cs_n=%0d", lo, hi, cs_n_a);

    // start and px_valid while a command byte is offered: both ignored.
    n = 0;
    while (!tx_valid_a && n < 50) begin @(negedge clk); n++; end
    check("first_offer_seen", int'(tx_valid_a), 1);
    start_a = 1'b1; px_valid_a = 1'b1; px_data_a = 8'hEE;
    #1;
    check("px_ready_in_send", int'(px_ready_a), 0);
    tick();
    start_a = 1'b0;
    @(negedge clk);
    check("start_ignored_busy", int'(busy_a), 1);
    check("start_ignored_lcd_rst_n", int'(lcd_rst_n_a), 1);
    check("px_ready_outside_stream", int'(px_ready_a), 0);
    px_valid_a = 1'b0;

    n = 0;
    while (!init_done_a && n < 400) begin @(negedge clk); n++; end
    check("init_done_a", int'(init_done_a), 1);
    check("rom_bytes_left_a", q_a.size(), 0);
    check("cs_n_in_stream", int'(cs_n_a), 0);
    $display("stream reached: init_done=%0d cycles_waited=%0d", init_done_a, n);

    // Pixel pass-through with serializer stalls.
    for (int i = 0; i < 4; i++) begin
      q_a.push_back('{px_tab[i].exp_data, px_tab[i].exp_dc, -1});
      tick();
      px_valid_a = 1'b1;
      px_data_a  = px_tab[i].px;
      stall_a    = (px_tab[i].stall != 0);
      @(negedge clk);
      check("stream_tx_valid", int'(tx_valid_a), 1);
      check("stream_tx_data", int'(tx_data_a), int'(px_tab[i].exp_data));
      check("px_ready_mirrors_tx_ready", int'(px_ready_a), int'(tx_ready_a));
      repeat (px_tab[i].stall) tick();
      stall_a = 1'b0;
      xc = xcnt_a;
      n = 0;
      while (xcnt_a == xc && n < 40) begin @(negedge clk); n++; end
      check("px_byte_accepted", xcnt_a - xc, 1);
      tick();
      px_valid_a = 1'b0;
    end
    n = 0;
    while (q_a.size() != 0 && n < 40) begin @(negedge clk); n++; end
    check("px_bytes_left_a", q_a.size(), 0);

    // start during STREAM: ignored.
    tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    @(negedge clk);
    check("stream_start_init_done", int'(init_done_a), 1);
    check("stream_start_lcd_rst_n", int'(lcd_rst_n_a), 1);
    check("stream_dc", int'(dc_a), 1);

    // Table without END: last slot forced to END after ROM_DEPTH-1 bytes.
    for (int i = 0; i < 7; i++) q_b.push_back('{8'hC0 + 8'(i), 1'b0, -1});
    tick();
    start_b = 1'b1; tick(); start_b = 1'b0;
    n = 0;
    while (!init_done_b && n < 400) begin @(negedge clk); n++; end
    check("init_done_b", int'(init_done_b), 1);
    check("rom_bytes_left_b", q_b.size(), 0);
    check("bytes_sent_b", xcnt_b, 7);
    repeat (20) tick();
    check("no_extra_bytes_b", xcnt_b, 7);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1);
  end

endmodule
